// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - byte-stream handshakes from the two requesters into the UART TX arbiter
interface uart_tx_arbiter_if;
  logic [7:0] req0_data;
  logic       req0_valid;
  logic       req0_last;
  logic       req0_ready;
  logic [7:0] req1_data;
  logic       req1_valid;
  logic       req1_last;
  logic       req1_ready;

  modport master (
    output req0_data, req0_valid, req0_last,
    output req1_data, req1_valid, req1_last,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_data, req0_valid, req0_last,
    input  req1_data, req1_valid, req1_last,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-locked round-robin arbiter for two byte streams feeding one 8N1 UART TX line
module uart_tx_arbiter #(
  parameter int CLKS_PER_BIT = 234,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic             CLK,
  input  logic             RESET,
  uart_tx_arbiter_if.slave req,
  output logic             ser_tx,
  output logic [1:0]       grant,
  output logic             busy
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          last_q, last_d;
  logic          lock_q, lock_d;
  logic          owner_q, owner_d;
  logic          rr_last_q, rr_last_d;
  logic          tx_q, tx_d;
  logic          sel, sel_valid, accept, baud_tick;

  // While locked only the owner is eligible; otherwise the requester that did not win last goes first.
  always_comb begin
    sel       = 1'b0;
    sel_valid = 1'b0;
    if (lock_q) begin
      sel       = owner_q;
      sel_valid = owner_q ? req.req1_valid : req.req0_valid;
    end else if (req.req0_valid && req.req1_valid) begin
      sel       = ~rr_last_q;
      sel_valid = 1'b1;
    end else if (req.req0_valid) begin
      sel_valid = 1'b1;
    end else if (req.req1_valid) begin
      sel       = 1'b1;
      sel_valid = 1'b1;
    end
  end

  assign accept         = (state_q == IDLE) && RESET && sel_valid;
  assign req.req0_ready = accept && !sel;
  assign req.req1_ready = accept && sel;
  assign baud_tick      = (baud_q == BAUD_MAX);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    last_d    = last_q;
    lock_d    = lock_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    tx_d      = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          baud_d    = '0;
          bit_d     = '0;
          shift_d   = sel ? req.req1_data : req.req0_data;
          last_d    = sel ? req.req1_last : req.req0_last;
          owner_d   = sel;
          lock_d    = 1'b1;
          rr_last_d = sel;
          tmo_d     = '0;
        end else if (lock_q && (LOCK_TIMEOUT != 0)) begin
          // Owner is idle here (otherwise it would have been accepted); rr_last is left alone on expiry.
          if (tmo_q == TMO_MAX) begin
            lock_d = 1'b0;
            tmo_d  = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      START: begin
        if (baud_tick) begin
          state_d = DATA;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_tick) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
          baud_d  = '0;
          if (last_q) begin
            lock_d = 1'b0;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The line is registered off the next state so it is glitch-free and snaps high on reset.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
      last_q    <= 1'b0;
      lock_q    <= 1'b0;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
      last_q    <= last_d;
      lock_q    <= lock_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      tx_q      <= tx_d;
    end
  end

  assign ser_tx = tx_q;
  assign busy   = (state_q != IDLE);
  assign grant  = (lock_q || busy) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench: message-level arbitration model plus UART receiver against uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int CPB   = 4;
  localparam int LT    = 16;
  localparam int FRAME = 10 * CPB;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ser_tx;
  logic       busy;
  logic [1:0] grant;

  uart_tx_arbiter_if rif ();

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB), .LOCK_TIMEOUT(LT)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .req    (rif),
    .ser_tx (ser_tx),
    .grant  (grant),
    .busy   (busy)
  );

  always #5 CLK = ~CLK;

  int         errors = 0;
  int         checks = 0;
  int         cyc    = 0;
  logic [7:0] exp_q[$];
  int         acc_id[$];
  int         acc_cyc[$];

  // Model state: who holds the line, who won last, when the line frees up.
  bit m_lock  = 1'b0;
  bit m_owner = 1'b0;
  bit m_rr    = 1'b1;
  bit m_rel   = 1'b0;
  int m_free  = 0;
  int m_idle  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Reference model: evaluated once per cycle from the arbitration rules.
  initial begin : model
    logic       e0, e1, line_idle, exp_busy, s;
    logic [1:0] exp_grant;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        m_lock = 1'b0; m_rr = 1'b1; m_rel = 1'b0; m_free = cyc; m_idle = 0;
        exp_q.delete();
        chk("reset_outputs", {rif.req0_ready, rif.req1_ready, busy, grant, ser_tx}, 6'b000001);
      end else begin
        if (rif.req0_valid && rif.req0_ready) begin acc_id.push_back(0); acc_cyc.push_back(cyc); end
        if (rif.req1_valid && rif.req1_ready) begin acc_id.push_back(1); acc_cyc.push_back(cyc); end
        line_idle = (cyc >= m_free);
        if (line_idle && m_rel) begin m_lock = 1'b0; m_rel = 1'b0; m_idle = 0; end
        e0 = 1'b0; e1 = 1'b0;
        if (line_idle) begin
          if (m_lock) begin
            if (m_owner) e1 = rif.req1_valid; else e0 = rif.req0_valid;
          end else if (rif.req0_valid && rif.req1_valid) begin
            if (m_rr) e0 = 1'b1; else e1 = 1'b1;
          end else begin
            e0 = rif.req0_valid; e1 = rif.req1_valid;
          end
        end
        exp_busy  = !line_idle;
        exp_grant = (m_lock || exp_busy) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        chk("cycle_outputs", {rif.req0_ready, rif.req1_ready, busy, grant}, {e0, e1, exp_busy, exp_grant});
        if (e0 || e1) begin
          s = e1;
          exp_q.push_back(s ? rif.req1_data : rif.req0_data);
          m_lock = 1'b1; m_owner = s; m_rr = s;
          m_rel  = s ? rif.req1_last : rif.req0_last;
          m_free = cyc + FRAME + 1;
          m_idle = 0;
        end else if (line_idle && m_lock) begin
          m_idle++;
          if (m_idle == LT) begin m_lock = 1'b0; m_idle = 0; end
        end
      end
    end
  end

  // UART receiver: samples mid-bit and checks each frame against the scoreboard.
  initial begin : rx
    bit         on;
    int         n, k;
    logic [9:0] fr;
    on = 1'b0; n = 0; fr = '0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        on = 1'b0;
      end else if (!on) begin
        if (ser_tx == 1'b0) begin on = 1'b1; n = 0; end
      end else begin
        n++;
        if (n % CPB == CPB / 2) begin
          k = n / CPB;
          fr[k] = ser_tx;
          if (k == 9) begin
            on = 1'b0;
            if (exp_q.size() == 0) chk("frame_unexpected", fr, 32'hFFFF_FFFF);
            else chk("frame", fr, {1'b1, exp_q.pop_front(), 1'b0});
          end
        end
      end
    end
  end

  task automatic send_byte(input int n, input logic [7:0] d, input logic l, input int gap);
    bit got;
    got = 1'b0;
    if (gap > 0) begin repeat (gap) @(posedge CLK); #1; end
    if (n == 0) begin rif.req0_data = d; rif.req0_last = l; rif.req0_valid = 1'b1; end
    else        begin rif.req1_data = d; rif.req1_last = l; rif.req1_valid = 1'b1; end
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge CLK);
      got = (n == 0) ? rif.req0_ready : rif.req1_ready;
    end
    @(posedge CLK); #1;
    if (n == 0) begin rif.req0_valid = 1'b0; rif.req0_data = 8'($urandom); rif.req0_last = 1'($urandom); end
    else        begin rif.req1_valid = 1'b0; rif.req1_data = 8'($urandom); rif.req1_last = 1'($urandom); end
    chk("accept_wait", got, 1);
  endtask

  task automatic rand_stream(input int n, input int nmsg);
    for (int m = 0; m < nmsg; m++) begin
      int len;
      len = int'($urandom_range(3, 1));
      for (int b = 0; b < len; b++)
        send_byte(n, 8'($urandom), (b == len - 1), (b == 0) ? int'($urandom_range(30, 0)) : int'($urandom_range(3, 0)));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge CLK); t++; end
    chk("drain", exp_q.size(), 0);
    repeat (CPB * 2) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1 RESET = 1'b0;
    repeat (2) @(posedge CLK); #1 RESET = 1'b1;
    acc_id.delete(); acc_cyc.delete();
  endtask

  task automatic chk_order(input string name, input int ids[4], input int cnt, input int spacing);
    chk({name, "_count"}, acc_id.size(), cnt);
    for (int i = 0; i < cnt && i < acc_id.size(); i++) chk({name, "_order"}, acc_id[i], ids[i]);
    for (int i = 1; i < cnt && i < acc_cyc.size(); i++) chk({name, "_spacing"}, acc_cyc[i] - acc_cyc[i-1], spacing);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin : main
    logic [9:0] fb;
    int         a;
    RESET = 1'b0;
    rif.req0_data = 8'hA5; rif.req0_last = 1'b1; rif.req0_valid = 1'b1;
    rif.req1_data = 8'h3C; rif.req1_last = 1'b1; rif.req1_valid = 1'b1;

    // Reset hold with both requesters valid, then first IDLE cycle goes to req0.
    repeat (3) @(negedge CLK);
    chk("reset_hold", {ser_tx, grant, busy, rif.req0_ready, rif.req1_ready}, 6'b100000);
    @(posedge CLK); #1 RESET = 1'b1;
    fork
      send_byte(0, 8'hA5, 1'b1, 0);
      send_byte(1, 8'h3C, 1'b1, 0);
      begin @(negedge CLK); chk("first_idle_ready", {rif.req0_ready, rif.req1_ready}, 2'b10); end
    join
    drain();

    // Single byte waveform, cycle by cycle.
    do_reset();
    send_byte(0, 8'hA5, 1'b1, 0);
    fb = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < FRAME; i++) begin
      @(negedge CLK);
      chk("single_frame", {ser_tx, busy, grant, rif.req0_ready}, {fb[i / CPB], 1'b1, 2'b01, 1'b0});
    end
    @(negedge CLK);
    chk("single_after", {busy, grant}, 3'b000);
    drain();

    // Round robin on single-byte messages.
    do_reset();
    fork
      begin send_byte(0, 8'h01, 1'b1, 0); send_byte(0, 8'h02, 1'b1, 0); end
      begin send_byte(1, 8'h81, 1'b1, 0); send_byte(1, 8'h82, 1'b1, 0); end
    join
    chk_order("rr", '{0, 1, 0, 1}, 4, FRAME + 1);
    drain();

    // Lock: req1's three-byte message is not interrupted by a waiting req0.
    do_reset();
    fork
      begin send_byte(1, 8'h11, 1'b0, 0); send_byte(1, 8'h22, 1'b0, 0); send_byte(1, 8'h33, 1'b1, 0); end
      send_byte(0, 8'h99, 1'b1, 3);
    join
    chk_order("lock", '{1, 1, 1, 0}, 4, FRAME + 1);
    drain();

    // Lock timeout: req0 goes quiet mid-message, req1 takes over after LT idle cycles.
    do_reset();
    send_byte(0, 8'h55, 1'b0, 0);
    fork send_byte(1, 8'h66, 1'b1, 0); join_none
    repeat (FRAME) @(negedge CLK);
    for (int i = 0; i < LT; i++) begin
      @(negedge CLK);
      chk("tmo_held", {grant, rif.req1_ready}, 3'b010);
    end
    @(negedge CLK);
    chk("tmo_release", rif.req1_ready, 1);
    @(negedge CLK);
    chk("tmo_grant", grant, 2'b10);
    wait fork;
    chk_order("tmo", '{0, 1, 0, 0}, 2, FRAME + 1 + LT);
    drain();

    // Reset during data bit 3 truncates the frame immediately.
    do_reset();
    send_byte(0, 8'hC3, 1'b1, 0);
    repeat (17) @(posedge CLK); #1;
    chk("mid_bit3", ser_tx, 0);
    RESET = 1'b0;
    #1;
    chk("mid_async", {ser_tx, grant, busy}, 4'b1000);
    repeat (2) @(posedge CLK); #1 RESET = 1'b1;
    send_byte(0, 8'h5A, 1'b1, 0);
    drain();

    // Random traffic against the model.
    do_reset();
    fork
      rand_stream(0, 10);
      rand_stream(1, 10);
    join
    drain();

    a = exp_q.size();
    chk("final_queue", a, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
